// File: rtl/demod_symbol_decision.sv
// Symbol decision: captures ten segment metrics and scans them one per clock for the maximum.
// Optional SOFT_METRIC_EN adds second-best tracking and a `margin` output (best - second).
module demod_symbol_decision #(
    parameter int unsigned SEG_W      = 32,
    parameter int          SIGNED_CMP = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [SEG_W-1:0] segment_0,
    input  logic [SEG_W-1:0] segment_1,
    input  logic [SEG_W-1:0] segment_2,
    input  logic [SEG_W-1:0] segment_3,
    input  logic [SEG_W-1:0] segment_4,
    input  logic [SEG_W-1:0] segment_5,
    input  logic [SEG_W-1:0] segment_6,
    input  logic [SEG_W-1:0] segment_7,
    input  logic [SEG_W-1:0] segment_8,
    input  logic [SEG_W-1:0] segment_9,
    output logic [3:0]       symbol,
    output logic [SEG_W-1:0] max_metric,
`ifdef SOFT_METRIC_EN
    output logic [SEG_W:0]   margin,
`endif
    output logic             valid,
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state_q, state_d;
    logic [SEG_W-1:0] seg_in [10];
    logic [SEG_W-1:0] bank_q [10];
    logic [SEG_W-1:0] bank_d [10];
    logic [3:0]       idx_q, idx_d;
    logic [3:0]       best_idx_q, best_idx_d;
    logic [SEG_W-1:0] best_q, best_d;
    logic [3:0]       symbol_q, symbol_d;
    logic [SEG_W-1:0] max_q, max_d;
    logic [3:0]       cand_idx;
    logic [SEG_W-1:0] cand;
`ifdef SOFT_METRIC_EN
    localparam logic [SEG_W-1:0] TYPE_MIN =
        (SIGNED_CMP != 0) ? {1'b1, {(SEG_W-1){1'b0}}} : '0;
    logic [SEG_W-1:0] second_q, second_d;
    logic [SEG_W:0]   margin_q, margin_d;
`endif

    assign seg_in[0] = segment_0;
    assign seg_in[1] = segment_1;
    assign seg_in[2] = segment_2;
    assign seg_in[3] = segment_3;
    assign seg_in[4] = segment_4;
    assign seg_in[5] = segment_5;
    assign seg_in[6] = segment_6;
    assign seg_in[7] = segment_7;
    assign seg_in[8] = segment_8;
    assign seg_in[9] = segment_9;

    function automatic logic gt(input logic [SEG_W-1:0] a, input logic [SEG_W-1:0] b);
        if (SIGNED_CMP != 0) return $signed(a) > $signed(b);
        else                 return a > b;
    endfunction

`ifdef SOFT_METRIC_EN
    // One extra bit keeps best - second exact for any operand pair.
    function automatic logic [SEG_W:0] ext(input logic [SEG_W-1:0] v);
        if (SIGNED_CMP != 0) return {v[SEG_W-1], v};
        else                 return {1'b0, v};
    endfunction
`endif

    assign cand_idx = idx_q + 4'd1;
    assign cand     = bank_q[cand_idx];

    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        idx_d      = idx_q;
        best_idx_d = best_idx_q;
        best_d     = best_q;
        symbol_d   = symbol_q;
        max_d      = max_q;
`ifdef SOFT_METRIC_EN
        second_d   = second_q;
        margin_d   = margin_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && in_valid) begin
                    bank_d     = seg_in;
                    idx_d      = '0;
                    best_idx_d = '0;
                    best_d     = seg_in[0];
`ifdef SOFT_METRIC_EN
                    second_d   = TYPE_MIN;
`endif
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                if (!start) begin
                    state_d = IDLE;
                end else begin
                    // Strictly greater only, so ties keep the lower index.
                    if (gt(cand, best_q)) begin
                        best_d     = cand;
                        best_idx_d = cand_idx;
`ifdef SOFT_METRIC_EN
                        second_d   = best_q;
                    end else if (gt(cand, second_q)) begin
                        second_d   = cand;
`endif
                    end
                    idx_d = cand_idx;
                    if (idx_q == 4'd8) begin
                        state_d  = DONE;
                        symbol_d = best_idx_d;
                        max_d    = best_d;
`ifdef SOFT_METRIC_EN
                        margin_d = ext(best_d) - ext(second_d);
`endif
                    end
                end
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
            symbol_q   <= '0;
            max_q      <= '0;
`ifdef SOFT_METRIC_EN
            second_q   <= '0;
            margin_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_idx_q <= best_idx_d;
            best_q     <= best_d;
            symbol_q   <= symbol_d;
            max_q      <= max_d;
`ifdef SOFT_METRIC_EN
            second_q   <= second_d;
            margin_q   <= margin_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign symbol     = symbol_q;
    assign max_metric = max_q;
`ifdef SOFT_METRIC_EN
    assign margin     = margin_q;
`endif
    assign valid      = (state_q == DONE);
    assign busy       = (state_q == SCAN);

endmodule

// File: tb/tb_demod_symbol_decision.sv
// Scoreboard bench: a signed and an unsigned instance share stimulus; monitors check each result.
module tb_demod_symbol_decision;

    typedef struct {
        logic [3:0]  sym;
        logic [31:0] met;
        logic [32:0] mrg;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, start, in_valid;
    logic [31:0] seg [10];
    logic [3:0]  symbol_s, symbol_u;
    logic [31:0] max_s, max_u;
    logic        valid_s, valid_u, busy_s, busy_u;
`ifdef SOFT_METRIC_EN
    logic [32:0] margin_s, margin_u;
`endif

    exp_t qs[$];
    exp_t qu[$];
    int   checks = 0;
    int   errors = 0;
    logic vprev_s = 1'b0;
    logic vprev_u = 1'b0;

    always #5 clk = ~clk;

    demod_symbol_decision #(.SEG_W(32), .SIGNED_CMP(1)) u_s (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .segment_0(seg[0]), .segment_1(seg[1]), .segment_2(seg[2]), .segment_3(seg[3]),
        .segment_4(seg[4]), .segment_5(seg[5]), .segment_6(seg[6]), .segment_7(seg[7]),
        .segment_8(seg[8]), .segment_9(seg[9]),
        .symbol(symbol_s), .max_metric(max_s),
`ifdef SOFT_METRIC_EN
        .margin(margin_s),
`endif
        .valid(valid_s), .busy(busy_s)
    );

    demod_symbol_decision #(.SEG_W(32), .SIGNED_CMP(0)) u_u (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
        .segment_0(seg[0]), .segment_1(seg[1]), .segment_2(seg[2]), .segment_3(seg[3]),
        .segment_4(seg[4]), .segment_5(seg[5]), .segment_6(seg[6]), .segment_7(seg[7]),
        .segment_8(seg[8]), .segment_9(seg[9]),
        .symbol(symbol_u), .max_metric(max_u),
`ifdef SOFT_METRIC_EN
        .margin(margin_u),
`endif
        .valid(valid_u), .busy(busy_u)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            chk("busy_valid_excl_s", {63'd0, busy_s & valid_s}, 64'd0);
            chk("busy_valid_excl_u", {63'd0, busy_u & valid_u}, 64'd0);
        end
        if (valid_s && !vprev_s) begin
            if (qs.size() == 0) begin
                chk("unexpected_result_s", 64'd1, 64'd0);
            end else begin
                e = qs.pop_front();
                chk("symbol_s", {60'd0, symbol_s}, {60'd0, e.sym});
                chk("max_metric_s", {32'd0, max_s}, {32'd0, e.met});
`ifdef SOFT_METRIC_EN
                chk("margin_s", {31'd0, margin_s}, {31'd0, e.mrg});
`endif
            end
        end
        if (valid_u && !vprev_u) begin
            if (qu.size() == 0) begin
                chk("unexpected_result_u", 64'd1, 64'd0);
            end else begin
                e = qu.pop_front();
                chk("symbol_u", {60'd0, symbol_u}, {60'd0, e.sym});
                chk("max_metric_u", {32'd0, max_u}, {32'd0, e.met});
`ifdef SOFT_METRIC_EN
                chk("margin_u", {31'd0, margin_u}, {31'd0, e.mrg});
`endif
            end
        end
        vprev_s = valid_s;
        vprev_u = valid_u;
    end

    task automatic push(input logic [3:0] ss, input logic [31:0] ms, input logic [32:0] gs,
                        input logic [3:0] su, input logic [31:0] mu, input logic [32:0] gu);
        exp_t e;
        e.sym = ss; e.met = ms; e.mrg = gs; qs.push_back(e);
        e.sym = su; e.met = mu; e.mrg = gu; qu.push_back(e);
    endtask

    task automatic wait_valid(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy_s) busy_cycles++;
            if (valid_s && valid_u) return;
        end
        chk("timeout_valid", 64'd0, 64'd1);
    endtask

    task automatic finish_scan();
        start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("valid_drop", {62'd0, valid_s, valid_u}, 64'd0);
    endtask

    task automatic clear_segs();
        for (int i = 0; i < 10; i++) seg[i] = 32'd0;
    endtask

    initial begin
        int bc;
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        clear_segs();
        repeat (2) @(negedge clk);
        chk("reset_state_s", {27'd0, valid_s, busy_s, symbol_s, max_s}, 64'd0);
        chk("reset_state_u", {27'd0, valid_u, busy_u, symbol_u, max_u}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // 1: seg k = 10k, seg7 = 1000
        for (int i = 0; i < 10; i++) seg[i] = 32'(i * 10);
        seg[7] = 32'd1000;
        push(4'd7, 32'd1000, 33'd910, 4'd7, 32'd1000, 33'd910);
        start = 1'b1; in_valid = 1'b1;
        wait_valid(bc);
        chk("busy_cycles", 64'(bc), 64'd9);
        repeat (3) @(negedge clk);
        chk("no_retrigger", {62'd0, valid_s, busy_s}, 64'd2);
        finish_scan();

        // 2: tie between seg2 and seg5
        clear_segs();
        seg[2] = 32'd500; seg[5] = 32'd500;
        push(4'd2, 32'd500, 33'd0, 4'd2, 32'd500, 33'd0);
        start = 1'b1; in_valid = 1'b1;
        wait_valid(bc);
        finish_scan();

        // 3: seg k = -k-1; -1 is largest both signed and unsigned
        for (int i = 0; i < 10; i++) seg[i] = -32'(i + 1);
        push(4'd0, 32'hFFFF_FFFF, 33'd1, 4'd0, 32'hFFFF_FFFF, 33'd1);
        start = 1'b1; in_valid = 1'b1;
        wait_valid(bc);
        finish_scan();

        // 3b: 0x8000_0000 is the minimum when signed, the maximum when unsigned
        for (int i = 0; i < 9; i++) seg[i] = 32'(i);
        seg[9] = 32'h8000_0000;
        push(4'd8, 32'd8, 33'd1, 4'd9, 32'h8000_0000, 33'h0_7FFF_FFF8);
        start = 1'b1; in_valid = 1'b1;
        wait_valid(bc);
        finish_scan();

        // 4: abort on the 4th scan cycle, then a fresh scan
        clear_segs();
        seg[0] = 32'd5000;
        start = 1'b1; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("abort_idle", {60'd0, valid_s, busy_s, valid_u, busy_u}, 64'd0);
        repeat (12) @(negedge clk);
        for (int i = 0; i < 10; i++) seg[i] = 32'd100;
        seg[6] = 32'd300; seg[1] = 32'd250;
        push(4'd6, 32'd300, 33'd50, 4'd6, 32'd300, 33'd50);
        start = 1'b1; in_valid = 1'b1;
        wait_valid(bc);
        finish_scan();

        // 5: reset mid-scan clears published outputs
        clear_segs();
        seg[1] = 32'd77;
        start = 1'b1; in_valid = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b1; start = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("midscan_reset_s", {27'd0, valid_s, busy_s, symbol_s, max_s}, 64'd0);
        chk("midscan_reset_u", {27'd0, valid_u, busy_u, symbol_u, max_u}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        // 5b: inputs change after capture; result follows the captured bank
        for (int i = 0; i < 10; i++) seg[i] = 32'd10;
        seg[4] = 32'd700;
        push(4'd4, 32'd700, 33'd690, 4'd4, 32'd700, 33'd690);
        start = 1'b1; in_valid = 1'b1;
        repeat (3) @(negedge clk);
        clear_segs();
        seg[9] = 32'd9999;
        wait_valid(bc);
        finish_scan();

        // 6: margin between the top two metrics
        clear_segs();
        seg[3] = 32'd900; seg[8] = 32'd850;
        push(4'd3, 32'd900, 33'd50, 4'd3, 32'd900, 33'd50);
        start = 1'b1; in_valid = 1'b1;
        wait_valid(bc);
        finish_scan();
        seg[8] = 32'd900;
        push(4'd3, 32'd900, 33'd0, 4'd3, 32'd900, 33'd0);
        start = 1'b1; in_valid = 1'b1;
        wait_valid(bc);
        finish_scan();

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(qs.size() + qu.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
